// File: rtl/psram_qpi_responder.sv
// QPI PSRAM responder: a 2^MEM_AW-byte memory behind a quad-SPI slave interface.
// Handles quad read (0xEB) and quad write (0x38) commands; any other command is ignored until CS rises.
module psram_qpi_responder #(
  parameter int MEM_AW      = 8,
  parameter int WAIT_CYCLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       psram_cs,
  input  logic       psram_sclk,
  input  logic [3:0] psram_sio_in,
  output logic [3:0] psram_sio_out,
  output logic       psram_sio_oe,
  output logic       cmd_err,
  output logic       active,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WAIT, S_WRDATA, S_RDDATA, S_IGNORE
  } state_t;

  // Handshake: no valid/ready; every bus event is a detected SCLK edge qualified by
  // synchronized CS low, and synchronized CS high beats any edge seen in the same clk.

  state_t            state_q, state_d;
  logic              cs_s1_q, cs_s2_q, cs_prev_q;
  logic              sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic [3:0]        sio_s1_q, sio_s2_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              is_rd_q, is_rd_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              nib_lo_q, nib_lo_d;
  logic [3:0]        hold_q, hold_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wr_pend_q, wr_pend_d;
  logic [3:0]        out_q, out_d;
  logic              oe_q, oe_d;
  logic              err_q, err_d;

  logic [7:0] mem [2**MEM_AW];
  logic [7:0] rd_byte;
  logic [7:0] cmd_byte;
  logic       sclk_rise, sclk_fall, cs_fall;

  assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
  assign cs_fall   = cs_prev_q & ~cs_s2_q;
  assign cmd_byte  = {cmd_q, sio_s2_q};
  assign rd_byte   = mem[addr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cs_s1_q     <= 1'b0;
      cs_s2_q     <= 1'b0;
      cs_prev_q   <= 1'b0;
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      sio_s1_q    <= '0;
      sio_s2_q    <= '0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      is_rd_q     <= 1'b0;
      addr_q      <= '0;
      nib_lo_q    <= 1'b0;
      hold_q      <= '0;
      wdata_q     <= '0;
      wr_pend_q   <= 1'b0;
      out_q       <= '0;
      oe_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_s1_q     <= psram_cs;
      cs_s2_q     <= cs_s1_q;
      cs_prev_q   <= cs_s2_q;
      sclk_s1_q   <= psram_sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sio_s1_q    <= psram_sio_in;
      sio_s2_q    <= sio_s1_q;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      is_rd_q     <= is_rd_d;
      addr_q      <= addr_d;
      nib_lo_q    <= nib_lo_d;
      hold_q      <= hold_d;
      wdata_q     <= wdata_d;
      wr_pend_q   <= wr_pend_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
    end
  end

  // Array is deliberately not reset; a pending write is dropped because reset clears wr_pend_q.
  always_ff @(posedge clk) begin
    if (wr_pend_q) mem[addr_q] <= wdata_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    nib_lo_d  = nib_lo_q;
    hold_d    = hold_q;
    wdata_d   = wdata_q;
    wr_pend_d = 1'b0;
    out_d     = out_q;
    oe_d      = oe_q;
    err_d     = 1'b0;

    if (wr_pend_q) addr_d = addr_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d  = S_CMD;
          cnt_d    = '0;
          nib_lo_d = 1'b0;
        end
      end
      S_CMD: begin
        if (sclk_rise) begin
          cmd_d = sio_s2_q;
          if (cnt_q == 8'd1) begin
            cnt_d = '0;
            if (cmd_byte == 8'hEB) begin
              state_d = S_ADDR;
              is_rd_d = 1'b1;
            end else if (cmd_byte == 8'h38) begin
              state_d = S_ADDR;
              is_rd_d = 1'b0;
            end else begin
              state_d = S_IGNORE;
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_ADDR: begin
        if (sclk_rise) begin
          // Shifting through an MEM_AW-wide register keeps only the low address bits.
          addr_d = (addr_q << 4) | MEM_AW'(sio_s2_q);
          if (cnt_q == 8'd5) begin
            state_d  = is_rd_q ? S_WAIT : S_WRDATA;
            cnt_d    = '0;
            nib_lo_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_WAIT: begin
        if (sclk_rise) begin
          if (cnt_q == 8'(WAIT_CYCLES - 1)) begin
            state_d  = S_RDDATA;
            nib_lo_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_RDDATA: begin
        if (sclk_fall) begin
          oe_d     = 1'b1;
          out_d    = nib_lo_q ? rd_byte[3:0] : rd_byte[7:4];
          nib_lo_d = ~nib_lo_q;
          if (nib_lo_q) addr_d = addr_q + 1'b1;
        end
      end
      S_WRDATA: begin
        if (sclk_rise) begin
          if (!nib_lo_q) begin
            hold_d   = sio_s2_q;
            nib_lo_d = 1'b1;
          end else begin
            wdata_d   = {hold_q, sio_s2_q};
            wr_pend_d = 1'b1;
            nib_lo_d  = 1'b0;
          end
        end
      end
      S_IGNORE: ;
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && cs_s2_q) begin
      state_d   = S_IDLE;
      oe_d      = 1'b0;
      out_d     = '0;
      err_d     = 1'b0;
      wr_pend_d = 1'b0;
    end
  end

  assign psram_sio_out = out_q;
  assign psram_sio_oe  = oe_q;
  assign cmd_err       = err_q;
  assign active        = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed plus randomized bench for psram_qpi_responder, acting as the QPI controller.
// Expected read data comes from a byte-array model of the memory updated on every write.
module tb_psram_qpi_responder;

  localparam int WAIT_CYCLES = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       psram_cs;
  logic       psram_sclk;
  logic [3:0] psram_sio_in;
  logic [3:0] psram_sio_out;
  logic       psram_sio_oe;
  logic       cmd_err;
  logic       active;
  logic [2:0] dbg_state;

  int checks = 0;
  int passed = 0;
  int err_pulses = 0;
  int oe_highs = 0;

  logic [7:0] model_mem [256];
  logic [7:0] wbuf [8];

  psram_qpi_responder #(.MEM_AW(8), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk           (clk),
    .reset         (reset),
    .psram_cs      (psram_cs),
    .psram_sclk    (psram_sclk),
    .psram_sio_in  (psram_sio_in),
    .psram_sio_out (psram_sio_out),
    .psram_sio_oe  (psram_sio_oe),
    .cmd_err       (cmd_err),
    .active        (active),
    .dbg_state_o   (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_err) err_pulses++;
    if (psram_sio_oe) oe_highs++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Driver tasks: data changes while SCLK is low, responder samples on SCLK rise.
  task automatic nib(input logic [3:0] n);
    psram_sio_in = n;
    wclk(2);
    psram_sclk = 1'b1;
    wclk(4);
    psram_sclk = 1'b0;
    wclk(2);
  endtask

  task automatic rd_nib(output logic [3:0] n, output logic oe);
    wclk(2);
    n  = psram_sio_out;
    oe = psram_sio_oe;
    psram_sclk = 1'b1;
    wclk(4);
    psram_sclk = 1'b0;
    wclk(2);
  endtask

  task automatic cs_start();
    psram_cs = 1'b0;
    wclk(4);
  endtask

  task automatic cs_end();
    psram_cs = 1'b1;
    wclk(6);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    nib(cmd[7:4]);
    nib(cmd[3:0]);
    for (int i = 5; i >= 0; i--) nib(addr[i*4 +: 4]);
  endtask

  task automatic write_bytes(input logic [23:0] addr, input int len);
    cs_start();
    send_hdr(8'h38, addr);
    for (int i = 0; i < len; i++) begin
      nib(wbuf[i][7:4]);
      nib(wbuf[i][3:0]);
      model_mem[(int'(addr[7:0]) + i) % 256] = wbuf[i];
    end
    cs_end();
  endtask

  task automatic read_check(input string tag, input logic [23:0] addr, input int len);
    logic [3:0] hi, lo;
    logic       oe_hi, oe_lo;
    cs_start();
    send_hdr(8'hEB, addr);
    check({tag, "_oe_pre"}, psram_sio_oe, 1'b0);
    repeat (WAIT_CYCLES) nib(4'($urandom_range(0, 15)));
    for (int i = 0; i < len; i++) begin
      rd_nib(hi, oe_hi);
      rd_nib(lo, oe_lo);
      check(tag, {hi, lo}, model_mem[(int'(addr[7:0]) + i) % 256]);
      check({tag, "_oe"}, {oe_hi, oe_lo}, 2'b11);
    end
    psram_cs = 1'b1;
    wclk(3);
    check({tag, "_end"}, {active, psram_sio_oe}, 2'b00);
    wclk(3);
  endtask

  initial begin
    logic [3:0] n;
    logic       oe;
    int         e0, o0, len;
    logic [7:0] a;

    reset        = 1'b1;
    psram_cs     = 1'b1;
    psram_sclk   = 1'b0;
    psram_sio_in = '0;
    wclk(3);
    check("reset_outs", {psram_sio_out, psram_sio_oe, cmd_err, active}, 7'd0);
    reset = 1'b0;
    wclk(4);
    check("idle_after_reset", {active, cmd_err}, 2'b00);

    // Basic write then read back
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    write_bytes(24'h000010, 2);
    read_check("rd_10", 24'h000010, 2);

    // Address wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_bytes(24'h0000FF, 2);
    read_check("rd_wrap", 24'h0000FF, 2);

    // Unsupported command
    e0 = err_pulses;
    o0 = oe_highs;
    cs_start();
    nib(4'h9);
    nib(4'hF);
    check("cmd_err_pulse", err_pulses - e0, 1);
    for (int i = 0; i < 10; i++) nib(4'($urandom_range(0, 15)));
    check("ignore_active", active, 1'b1);
    cs_end();
    check("cmd_err_once", err_pulses - e0, 1);
    check("ignore_no_oe", oe_highs - o0, 0);
    read_check("rd_after_ign", 24'h000010, 2);

    // Partial byte is dropped at CS high
    wbuf[0] = 8'h5A;
    write_bytes(24'h000020, 1);
    cs_start();
    send_hdr(8'h38, 24'h000020);
    nib(4'h7);
    check("partial_active", active, 1'b1);
    psram_cs = 1'b1;
    wclk(3);
    check("partial_cs_high", {active, psram_sio_oe}, 2'b00);
    wclk(3);
    read_check("rd_partial", 24'h000020, 1);

    // Upper address bits are ignored
    wbuf[0] = 8'hC7;
    write_bytes(24'hAB0033, 1);
    read_check("rd_upper", 24'h000033, 1);

    // Reset in the middle of a read
    cs_start();
    send_hdr(8'hEB, 24'h000010);
    repeat (WAIT_CYCLES) nib(4'($urandom_range(0, 15)));
    rd_nib(n, oe);
    check("mid_rd_hi", {n, oe}, {4'hA, 1'b1});
    reset = 1'b1;
    #1;
    check("mid_rd_reset", {psram_sio_out, psram_sio_oe, cmd_err, active}, 7'd0);
    wclk(2);
    reset = 1'b0;
    psram_cs = 1'b1;
    wclk(4);
    read_check("rd_post_reset", 24'h000010, 2);

    // Randomized write/read-back against the model
    for (int t = 0; t < 8; t++) begin
      a   = 8'($urandom_range(0, 255));
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom_range(0, 255));
      write_bytes({8'($urandom_range(0, 255)), 8'h00, a}, len);
      read_check("rd_rand", {16'h0000, a}, len);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
